// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and default widths for the signed MAC accumulator
package mac_pkg;
  localparam int PROD_W = 16;
  localparam int ACC_W = 24;
  localparam int LEN_W = 8;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/signed_mac_acc_if.sv
// signed_mac_acc_if: control, product-in and result-out handshake bundle of the MAC accumulator
interface signed_mac_acc_if #(
  parameter int PROD_W = mac_pkg::PROD_W,
  parameter int ACC_W = mac_pkg::ACC_W,
  parameter int LEN_W = mac_pkg::LEN_W
);
  logic start, clear, prod_valid, prod_ready, res_valid, res_ready, ovf, busy;
  logic [LEN_W-1:0] len;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] res;
  modport master(
    output start, len, clear, prod, prod_valid, res_ready,
    input prod_ready, res, res_valid, ovf, busy
  );
  modport slave(
    input start, len, clear, prod, prod_valid, res_ready,
    output prod_ready, res, res_valid, ovf, busy
  );
endinterface

// File: rtl/mac_add_ovf.sv
// mac_add_ovf: sign-extending accumulator adder with overflow detect; MAC_SATURATE_EN enables clamping
module mac_add_ovf #(
  parameter int PROD_W = mac_pkg::PROD_W,
  parameter int ACC_W = mac_pkg::ACC_W
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);
  logic signed [ACC_W-1:0] ext, raw;
  assign ext = prod;
  assign raw = acc + ext;
  assign ovf = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
`ifdef MAC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // both operands share a sign on overflow, so acc's sign picks the rail
  assign sum = ovf ? (acc[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/signed_mac_acc.sv
// signed_mac_acc: sums len signed products into a wide accumulator and hands out the result with sticky overflow.
// Define MAC_SATURATE_EN to clamp on overflow instead of wrapping. Parameters must match the bus instance.
module signed_mac_acc #(
  parameter int PROD_W = mac_pkg::PROD_W,
  parameter int ACC_W = mac_pkg::ACC_W,
  parameter int LEN_W = mac_pkg::LEN_W
) (
  input logic clk,
  input logic rst_n,
  signed_mac_acc_if.slave bus
);
  import mac_pkg::*;
  state_t state;
  logic [LEN_W-1:0] cnt;
  logic signed [ACC_W-1:0] acc, sum;
  logic ovf_q, res_valid_q, add_ovf, beat;
  mac_add_ovf #(.PROD_W(PROD_W), .ACC_W(ACC_W)) u_add (
    .acc(acc),
    .prod(bus.prod),
    .sum(sum),
    .ovf(add_ovf)
  );
  assign bus.prod_ready = state == ACCUM;
  assign bus.busy = state != IDLE;
  assign bus.res = acc;
  assign bus.ovf = ovf_q;
  assign bus.res_valid = res_valid_q;
  assign beat = bus.prod_valid && bus.prod_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (bus.clear) begin
      state <= IDLE;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          acc <= '0;
          ovf_q <= 1'b0;
          cnt <= bus.len;
          state <= bus.len == '0 ? DONE : ACCUM;
          res_valid_q <= bus.len == '0;
        end
        ACCUM: if (beat) begin
          acc <= sum;
          ovf_q <= ovf_q | add_ovf;
          cnt <= cnt - 1'b1;
          if (cnt == LEN_W'(1)) begin
            state <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.res_ready) begin
          state <= IDLE;
          res_valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_mac_acc.sv
// tb_signed_mac_acc: scoreboard bench driving a 24-bit and a 16-bit accumulator with identical stimulus
module tb_signed_mac_acc;
  localparam int PW = 16, LW = 8, AW = 24, AN = 16;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic start = 0, clear = 0, prod_valid = 0, res_ready = 0;
  logic [LW-1:0] len = 0;
  logic signed [PW-1:0] prod = 0;
  int rr_mode = 0;
  int tests = 0, fails = 0;
  typedef struct {longint rw; bit ow; longint rn; bit on;} exp_t;
  exp_t q[$];

  signed_mac_acc_if #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) bw();
  signed_mac_acc_if #(.PROD_W(PW), .ACC_W(AN), .LEN_W(LW)) bn();
  assign bw.start = start;
  assign bw.len = len;
  assign bw.clear = clear;
  assign bw.prod = prod;
  assign bw.prod_valid = prod_valid;
  assign bw.res_ready = res_ready;
  assign bn.start = start;
  assign bn.len = len;
  assign bn.clear = clear;
  assign bn.prod = prod;
  assign bn.prod_valid = prod_valid;
  assign bn.res_ready = res_ready;

  signed_mac_acc #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bw));
  signed_mac_acc #(.PROD_W(PW), .ACC_W(AN), .LEN_W(LW)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bn));

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: exact integer sum, folded back into a w-bit signed range on overflow
  function automatic void model(input int w, input longint p[$], output longint r, output bit o);
    longint mx, mn, a, s;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    a = 0;
    o = 0;
    foreach (p[i]) begin
      s = a + p[i];
      if (s > mx || s < mn) begin
        o = 1;
`ifdef MAC_SATURATE_EN
        s = s > mx ? mx : mn;
`else
        s = s > mx ? s - (mx - mn + 1) : s + (mx - mn + 1);
`endif
      end
      a = s;
    end
    r = a;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rr_mode == 0) res_ready = $urandom_range(0, 2) != 0;
  end

  bit held = 0;
  longint hw, hn;
  bit how, hon;
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && bw.res_valid) begin
      chk("done_prod_ready", bw.prod_ready, 0);
      chk("valid_sync", bn.res_valid, 1);
      if (held) begin
        chk("stall_res_w", bw.res, hw);
        chk("stall_ovf_w", bw.ovf, how);
        chk("stall_res_n", bn.res, hn);
        chk("stall_ovf_n", bn.ovf, hon);
      end
      if (res_ready) begin
        held = 0;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_result: got res=%0d with empty queue", bw.res);
        end else begin
          tests--;
          e = q.pop_front();
          chk("res_w", bw.res, e.rw);
          chk("ovf_w", bw.ovf, longint'(e.ow));
          chk("res_n", bn.res, e.rn);
          chk("ovf_n", bn.ovf, longint'(e.on));
        end
      end else begin
        held = 1;
        hw = bw.res;
        hn = bn.res;
        how = bw.ovf;
        hon = bn.ovf;
      end
    end else held = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bw.busy && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", bw.busy, 0);
  endtask

  // gaps[i] bubbles precede beat i; an empty gap list means random bubbles
  task automatic run(input longint p[$], input int g[$]);
    exp_t x;
    int nb;
    start = 1;
    len = LW'(p.size());
    step();
    start = 0;
    foreach (p[i]) begin
      nb = g.size() > i ? g[i] : (($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : 0);
      repeat (nb) begin
        prod_valid = 0;
        prod = PW'($urandom);
        step();
      end
      chk("accum_prod_ready", bw.prod_ready, 1);
      prod_valid = 1;
      prod = PW'(p[i]);
      step();
      prod_valid = 0;
    end
    model(AW, p, x.rw, x.ow);
    model(AN, p, x.rn, x.on);
    q.push_back(x);
    chk("latency_valid", bw.res_valid, 1);
    if (p.size() == 0) chk("zero_len_prod_ready", bw.prod_ready, 0);
  endtask

  initial begin
    longint p[$];
    int g[$];
    logic signed [PW-1:0] r16;
    repeat (3) step();
    chk("rst_res", bw.res, 0);
    chk("rst_ovf", bw.ovf, 0);
    chk("rst_valid", bw.res_valid, 0);
    chk("rst_prod_ready", bw.prod_ready, 0);
    chk("rst_busy", bw.busy, 0);
    rst_n = 1;
    step();
    g = {};
    p = {100, -50, 16384, -16256};
    run(p, g);
    wait_idle();
    p = {};
    run(p, g);
    wait_idle();
    p = {16384, 16384};
    run(p, g);
    wait_idle();
    p = {7, -3, 2};
    g = {0, 2, 1};
    run(p, g);
    wait_idle();
    g = {};
    rr_mode = 1;
    res_ready = 0;
    p = {-32768, -32768, 1234};
    run(p, g);
    step();
    start = 1;
    len = 3;
    step();
    start = 0;
    repeat (3) step();
    chk("stall_busy", bw.busy, 1);
    res_ready = 1;
    step();
    res_ready = 0;
    chk("stall_release_idle", bw.busy, 0);
    step();
    chk("stall_start_ignored", bw.busy, 0);
    p = {11, 22};
    run(p, g);
    start = 1;
    len = 2;
    res_ready = 1;
    step();
    start = 0;
    res_ready = 0;
    chk("done_start_ignored", bw.busy, 0);
    rr_mode = 0;
    start = 1;
    len = 5;
    step();
    start = 0;
    repeat (2) begin
      prod_valid = 1;
      prod = 300;
      step();
    end
    prod_valid = 1;
    clear = 1;
    step();
    clear = 0;
    prod_valid = 0;
    repeat (3) begin
      chk("abort_valid", bw.res_valid, 0);
      chk("abort_busy", bw.busy, 0);
      step();
    end
    p = {-1};
    run(p, g);
    wait_idle();
    start = 1;
    len = 4;
    step();
    start = 0;
    repeat (2) begin
      prod_valid = 1;
      prod = 250;
      step();
    end
    prod_valid = 0;
    chk("pre_rst_acc", bw.res, 500);
    rst_n = 0;
    step();
    chk("mid_rst_res", bw.res, 0);
    chk("mid_rst_ovf", bw.ovf, 0);
    chk("mid_rst_valid", bw.res_valid, 0);
    chk("mid_rst_busy", bw.busy, 0);
    rst_n = 1;
    repeat (4) begin
      prod_valid = 1;
      prod = 77;
      step();
      chk("post_rst_no_beat", bw.prod_ready, 0);
      chk("post_rst_idle", bw.busy, 0);
    end
    prod_valid = 0;
    for (int t = 0; t < 40; t++) begin
      p = {};
      repeat ($urandom_range(0, 12)) begin
        r16 = PW'($urandom);
        p.push_back(r16);
      end
      run(p, g);
      wait_idle();
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (5) step();
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
